// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port synchronous
// data memory among NUM_CORES requesting cores.
// Each transfer is IDLE (sample/grant) -> ACCESS (memory port driven) -> RESP (ack).
// Optional build macro DMEM_ARB_GRANT_CNT_EN adds one saturating 16-bit
// grant counter per core on output grant_cnt.
module dmem_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            req,
    input  logic [NUM_CORES-1:0]            we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CORES-1:0]            ack,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_we,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            busy
`ifdef DMEM_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_CORES*16-1:0]         grant_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Request captured at grant time; later input changes do not affect it.
    typedef struct packed {
        logic [PTR_W-1:0]      id;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } xfer_t;

    state_t                state, state_n;
    xfer_t                 xfer;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      win;
    logic [PTR_W:0]        idx;
    logic                  any_req;
    logic                  grant;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Winner search: first set req starting at rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        any_req = |req;
        win     = rr_ptr;
        idx     = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_CORES))
                idx = idx - (PTR_W+1)'(NUM_CORES);
            if (req[idx[PTR_W-1:0]])
                win = idx[PTR_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; grant fires on the IDLE cycle that sees a request.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS:  state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Transfer latch, round-robin pointer and held read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            xfer    <= '0;
            rr_ptr  <= '0;
            rdata_q <= '0;
        end else begin
            if (grant) begin
                xfer.id    <= win;
                xfer.we    <= we[win];
                xfer.addr  <= addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                xfer.wdata <= wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == RESP) begin
                rr_ptr <= (xfer.id == PTR_W'(NUM_CORES - 1)) ? '0 : xfer.id + 1'b1;
                if (!xfer.we)
                    rdata_q <= mem_rdata;
            end
        end
    end

    // Memory port follows the latch, so it holds its last values outside ACCESS.
    // Reset gates mem_we and ack in the cycle it is asserted so an aborted
    // transfer neither writes nor acknowledges.
    assign mem_addr  = xfer.addr;
    assign mem_wdata = xfer.wdata;
    assign mem_we    = (state == ACCESS) && xfer.we && reset;
    assign ack       = (state == RESP && reset) ? (NUM_CORES'(1) << xfer.id) : '0;
    assign busy      = (state != IDLE);
    // Synchronous memory returns data in RESP; pass it straight through for reads.
    assign rdata     = (state == RESP && !xfer.we) ? mem_rdata : rdata_q;

`ifdef DMEM_ARB_GRANT_CNT_EN
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_cnt
        logic [15:0] cnt;
        // Per-core saturating count of completed transfers.
        always_ff @(posedge clk) begin
            if (!reset)
                cnt <= '0;
            else if (ack[i] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign grant_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level reference model of the round-robin arbiter.
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata, mem_addr, mem_wdata, mem_rdata;
    logic            mem_we, busy;
`ifdef DMEM_ARB_GRANT_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [256] = '{default: 8'h00};

    dmem_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_GRANT_CNT_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory, read-before-write.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic set_core(input int i, input logic r, input logic w,
                            input logic [7:0] a, input logic [7:0] d);
        req[i] = r;
        we[i]  = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    // Waits (bounded) for an ack; drops that core's req in the ack cycle.
    task automatic wait_ack(output int who);
        who = -1;
        for (int c = 0; c < 12 && who < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (ack[i]) begin
                    who = i;
                    req[i] = 1'b0;
                end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        req = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ack, busy, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_state: ack=%b busy=%b mem_we=%b mem_addr=%h mem_wdata=%h rdata=%h, want all 0",
                     ack, busy, mem_we, mem_addr, mem_wdata, rdata);
        end
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ack, busy, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
                n_err++;
                $display("FAIL idle_after_reset c%0d: ack=%b busy=%b mem_we=%b mem_addr=%h rdata=%h, want all 0",
                         c, ack, busy, mem_we, mem_addr, rdata);
            end
        end
    endtask

    task automatic test_single_write();
        set_core(2, 1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5 || ack !== 4'b0000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL write_access: mem_we=%b mem_addr=%h mem_wdata=%h ack=%b busy=%b, want 1 10 a5 0000 1",
                     mem_we, mem_addr, mem_wdata, ack, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (ack !== 4'b0100 || mem_we !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL write_ack: ack=%b mem_we=%b busy=%b, want 0100 0 1", ack, mem_we, busy);
        end
        req[2] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ack !== 4'b0000 || busy !== 1'b0 || mem[8'h10] !== 8'hA5) begin
            n_err++;
            $display("FAIL write_done: ack=%b busy=%b mem[10]=%h, want 0000 0 a5", ack, busy, mem[8'h10]);
        end
    endtask

    task automatic test_single_read();
        set_core(1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 8'h10 || ack !== 4'b0000) begin
            n_err++;
            $display("FAIL read_access: mem_we=%b mem_addr=%h ack=%b, want 0 10 0000", mem_we, mem_addr, ack);
        end
        @(negedge clk);
        n_cmp++;
        if (ack !== 4'b0010 || rdata !== 8'hA5 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL read_ack: ack=%b rdata=%h mem_we=%b, want 0010 a5 0", ack, rdata, mem_we);
        end
        req[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdata !== 8'hA5 || ack !== 4'b0000 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL read_hold: rdata=%h ack=%b mem_we=%b, want a5 0000 0", rdata, ack, mem_we);
        end
    endtask

    task automatic test_contention();
        int order[$];
        int times[$];
        pulse_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 8'h40 + 8'(i), 8'h00);
        for (int c = 1; c <= 20 && order.size() < N; c++) begin
            @(negedge clk);
            n_cmp++;
            if (!$onehot0(ack)) begin
                n_err++;
                $display("FAIL contention_overlap c%0d: ack=%b, want at most one bit", c, ack);
            end
            for (int i = 0; i < N; i++)
                if (ack[i]) begin
                    order.push_back(i);
                    times.push_back(c);
                    req[i] = 1'b0;
                end
        end
        n_cmp++;
        if (order.size() != N) begin
            n_err++;
            $display("FAIL contention_count: got %0d acks, want %0d", order.size(), N);
        end
        for (int k = 0; k < order.size(); k++) begin
            n_cmp++;
            if (order[k] != k) begin
                n_err++;
                $display("FAIL contention_order[%0d]: core %0d, want %0d", k, order[k], k);
            end
            n_cmp++;
            if (times[k] != 2 + 3 * k) begin
                n_err++;
                $display("FAIL contention_time[%0d]: cycle %0d, want %0d", k, times[k], 2 + 3 * k);
            end
        end
    endtask

    task automatic test_rr_wrap();
        int who;
        @(negedge clk);
        set_core(3, 1'b1, 1'b0, 8'h43, 8'h00);
        wait_ack(who);
        n_cmp++;
        if (who != 3) begin n_err++; $display("FAIL wrap_first: core %0d, want 3", who); end
        @(negedge clk);
        set_core(0, 1'b1, 1'b0, 8'h40, 8'h00);
        set_core(3, 1'b1, 1'b0, 8'h43, 8'h00);
        wait_ack(who);
        n_cmp++;
        if (who != 0) begin n_err++; $display("FAIL wrap_second: core %0d, want 0", who); end
        wait_ack(who);
        n_cmp++;
        if (who != 3) begin n_err++; $display("FAIL wrap_third: core %0d, want 3", who); end
    endtask

    task automatic test_reset_mid_access();
        int who;
        @(negedge clk);
        set_core(1, 1'b1, 1'b0, 8'h41, 8'h00);
        wait_ack(who);
        n_cmp++;
        if (who != 1) begin n_err++; $display("FAIL mid_setup: core %0d, want 1", who); end
        @(negedge clk);
        set_core(2, 1'b1, 1'b1, 8'h20, 8'h5A);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1) begin n_err++; $display("FAIL mid_access: mem_we=%b, want 1", mem_we); end
        reset = 1'b0;
        req[2] = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || ack !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset_cycle: mem_we=%b ack=%b, want 0 0000", mem_we, ack);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ack !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin
            n_err++;
            $display("FAIL mid_after_reset: busy=%b ack=%b mem_we=%b mem_addr=%h, want 0 0000 0 00",
                     busy, ack, mem_we, mem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem[8'h20] !== 8'h00 || ack !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_no_write: mem[20]=%h ack=%b, want 00 0000", mem[8'h20], ack);
        end
        set_core(1, 1'b1, 1'b0, 8'h41, 8'h00);
        set_core(3, 1'b1, 1'b0, 8'h43, 8'h00);
        wait_ack(who);
        n_cmp++;
        if (who != 1) begin n_err++; $display("FAIL mid_next_grant: core %0d, want 1", who); end
        wait_ack(who);
        n_cmp++;
        if (who != 3) begin n_err++; $display("FAIL mid_following: core %0d, want 3", who); end
    endtask

    task automatic test_random();
        int st, g, rr, who;
        logic t_we;
        logic [7:0] t_addr, t_wd, exp_rd, exp_ma, exp_mwd;
        logic [N-1:0] exp_ack;
        logic [7:0] ref_mem [256];
        int waits[N];
        for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
        for (int i = 0; i < N; i++) waits[i] = 0;
        @(negedge clk);
        pulse_reset();
        st = 0; g = 0; rr = 0; t_we = 1'b0; t_addr = '0; t_wd = '0;
        exp_rd = '0; exp_ma = '0; exp_mwd = '0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            exp_ack = (st == 2) ? N'(1 << g) : '0;
            n_cmp++;
            if (ack !== exp_ack) begin
                n_err++;
                $display("FAIL rnd_ack c%0d: ack=%b, want %b", cyc, ack, exp_ack);
            end
            n_cmp++;
            if (busy !== (st != 0)) begin
                n_err++;
                $display("FAIL rnd_busy c%0d: busy=%b, want %b", cyc, busy, st != 0);
            end
            n_cmp++;
            if (mem_we !== (st == 1 && t_we)) begin
                n_err++;
                $display("FAIL rnd_mem_we c%0d: mem_we=%b, want %b", cyc, mem_we, st == 1 && t_we);
            end
            n_cmp++;
            if (mem_addr !== exp_ma || mem_wdata !== exp_mwd) begin
                n_err++;
                $display("FAIL rnd_mem_port c%0d: addr=%h wdata=%h, want %h %h", cyc, mem_addr, mem_wdata, exp_ma, exp_mwd);
            end
            if (st == 2 && !t_we) begin
                n_cmp++;
                if (rdata !== exp_rd) begin
                    n_err++;
                    $display("FAIL rnd_rdata c%0d: rdata=%h, want %h", cyc, rdata, exp_rd);
                end
            end
            // Fairness: a pending core sees at most N-1 other grants before its own.
            who = -1;
            for (int i = 0; i < N; i++) if (ack[i]) who = i;
            if (who >= 0) begin
                n_cmp++;
                if (waits[who] > N - 1) begin
                    n_err++;
                    $display("FAIL rnd_fair c%0d: core %0d waited %0d grants, want <= %0d", cyc, who, waits[who], N - 1);
                end
                waits[who] = 0;
                for (int i = 0; i < N; i++) if (i != who && req[i]) waits[i]++;
            end
            // Core behaviour.
            for (int i = 0; i < N; i++) begin
                if (st == 2 && g == i) begin
                    req[i] = 1'b0;
                end else if (st != 0 && g == i) begin
                    if ($urandom_range(7) == 0) req[i] = 1'b0;
                    we[i] = 1'($urandom);
                    addr[i*AW +: AW]  = 8'($urandom);
                    wdata[i*DW +: DW] = 8'($urandom);
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    set_core(i, 1'b1, 1'($urandom), 8'h80 | 8'($urandom_range(15)), 8'($urandom));
                    waits[i] = 0;
                end
            end
            // Reference: what the arbiter does at the coming edge.
            case (st)
                0: if (req != '0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req[(rr + k) % N]) g = (rr + k) % N;
                    t_we   = we[g];
                    t_addr = addr[g*AW +: AW];
                    t_wd   = wdata[g*DW +: DW];
                    exp_ma = t_addr;
                    exp_mwd = t_wd;
                    st = 1;
                end
                1: begin
                    if (t_we) ref_mem[t_addr] = t_wd;
                    else exp_rd = ref_mem[t_addr];
                    st = 2;
                end
                default: begin
                    rr = (g + 1) % N;
                    st = 0;
                end
            endcase
        end
        req = '0;
        repeat (4) @(negedge clk);
        for (int a = 8'h80; a < 8'h90; a++) begin
            n_cmp++;
            if (mem[a] !== ref_mem[a]) begin
                n_err++;
                $display("FAIL rnd_mem[%h]: %h, want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

`ifdef DMEM_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        int who;
        @(negedge clk);
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            set_core(1, 1'b1, 1'b0, 8'h11, 8'h00);
            wait_ack(who);
            @(negedge clk);
        end
        n_cmp++;
        if (grant_cnt !== {16'd0, 16'd0, 16'd5, 16'd0}) begin
            n_err++;
            $display("FAIL grant_cnt: %h, want 0000000000050000", grant_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_rr_wrap();
        test_reset_mid_access();
        test_random();
`ifdef DMEM_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
